// File: rtl/sdram_pkg.sv
// Shared types and constants for the buffered SDRAM request front-end.
// Request record, queue FSM states and the word-alignment mask for sd_addr.
package sdram_pkg;

  localparam int SD_ADDR_W   = 32;
  localparam int SD_DATA_W   = 32;
  localparam int SD_BYTE_LSB = $clog2(SD_DATA_W / 8);
  localparam logic [SD_ADDR_W-1:0] SD_ADDR_MASK = {SD_ADDR_W{1'b1}} << SD_BYTE_LSB;

  typedef struct packed {
    logic                 we;
    logic [SD_ADDR_W-1:0] addr;
    logic [SD_DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } q_state_e;

  function automatic logic [SD_ADDR_W-1:0] word_align(input logic [SD_ADDR_W-1:0] a);
    return a & SD_ADDR_MASK;
  endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit so full and empty differ.
// req_ready is registered from the next-state pointers, so it is low while in reset.
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  req_t        i_data,
  output logic        o_ready,
  input  logic        i_pop,
  output req_t        o_data,
  output logic        o_empty,
  output logic [AW:0] o_count
);

  req_t        r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_ready;
  logic        w_push;
  logic        w_pop;
  logic [AW:0] w_wptr_nxt;
  logic [AW:0] w_rptr_nxt;

  assign w_push     = i_push & r_ready;
  assign w_pop      = i_pop & ~o_empty;
  assign w_wptr_nxt = r_wptr + (AW+1)'(w_push);
  assign w_rptr_nxt = r_rptr + (AW+1)'(w_pop);

  assign o_empty = (r_wptr == r_rptr);
  assign o_count = r_wptr - r_rptr;
  assign o_ready = r_ready;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_ready <= (w_wptr_nxt - w_rptr_nxt) != (AW+1)'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/sdram_req_queue.sv
// Buffered front-end for sdram_core: queues requests, issues one command at a time,
// returns in-order responses and flags commands whose completion never arrives.
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter  int ADDR_WIDTH  = SD_ADDR_W,
  parameter  int DATA_WIDTH  = SD_DATA_W,
  parameter  int DEPTH       = 8,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int CW          = $clog2(DEPTH) + 1,
  localparam int TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sd_addr,
  output logic [DATA_WIDTH-1:0] sd_wdata,
  output logic                  sd_wr,
  output logic                  sd_rd,
  input  logic                  sd_rdy,
  input  logic                  sd_wvalid,
  input  logic                  sd_rvalid,
  input  logic [DATA_WIDTH-1:0] sd_rdata,
  output logic                  err_timeout,
  output logic [CW-1:0]         occupancy
);

  q_state_e              r_state;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_sd_addr;
  logic [DATA_WIDTH-1:0] r_sd_wdata;
  logic                  r_sd_wr;
  logic                  r_sd_rd;
  logic [TW-1:0]         r_timer;
  logic                  r_rsp_valid;
  logic                  r_rsp_we;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_err;

  req_t w_push_req;
  req_t w_head;
  logic w_empty;
  logic w_pop;
  logic w_done;

  assign w_push_req = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign w_pop      = (r_state == IDLE) && !w_empty;
  // Only the completion matching the outstanding command type counts.
  assign w_done     = r_we ? sd_wvalid : sd_rvalid;

  sdram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (req_valid),
    .i_data  (w_push_req),
    .o_ready (req_ready),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (occupancy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_sd_addr   <= '0;
      r_sd_wdata  <= '0;
      r_sd_wr     <= 1'b0;
      r_sd_rd     <= 1'b0;
      r_timer     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_we       <= w_head.we;
            r_sd_addr  <= word_align(w_head.addr);
            r_sd_wdata <= w_head.we ? w_head.wdata : '0;
            r_sd_wr    <= w_head.we;
            r_sd_rd    <= !w_head.we;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (sd_rdy) begin
            r_sd_wr    <= 1'b0;
            r_sd_rd    <= 1'b0;
            r_sd_wdata <= '0;
            r_timer    <= '0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= r_we;
            r_rsp_rdata <= r_we ? '0 : sd_rdata;
            r_state     <= RESP;
          end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
            // Abandon the command: report it with zero data and flag the error.
            r_err       <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= r_we;
            r_rsp_rdata <= '0;
            r_state     <= RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sd_addr     = r_sd_addr;
  assign sd_wdata    = r_sd_wdata;
  assign sd_wr       = r_sd_wr;
  assign sd_rd       = r_sd_rd;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_we      = r_rsp_we;
  assign rsp_rdata   = r_rsp_rdata;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_sdram_req_queue.sv
// Bench for sdram_req_queue: behavioural sdram_core stub, request/response scoreboard,
// a vector table plus hand-written sequences for fill, timeout, spurious completion and reset.
module tb_sdram_req_queue;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int TMO   = 1024;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_rdata;
    int            rdy_dly;
    int            cmp_dly;
    bit            idle_rdy;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } iss_t;

  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_wdata;
  logic sd_wr, sd_rd, sd_rdy, sd_wvalid, sd_rvalid;
  logic [DW-1:0] sd_rdata;
  logic err_timeout;
  logic [$clog2(DEPTH):0] occupancy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_dly = 0, cmp_dly = 0, issue_cnt = 0, acc_cyc = 0;
  bit idle_rdy = 0, never_cmp = 0, spur_now = 0, consume_en = 1;
  logic [DW-1:0] smem [logic [AW-1:0]];
  iss_t exp_issue_q[$];
  rsp_t exp_rsp_q[$];

  sdram_req_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .sd_addr(sd_addr), .sd_wdata(sd_wdata), .sd_wr(sd_wr), .sd_rd(sd_rd),
    .sd_rdy(sd_rdy), .sd_wvalid(sd_wvalid), .sd_rvalid(sd_rvalid), .sd_rdata(sd_rdata),
    .err_timeout(err_timeout), .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic fail(input string n, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", n, why);
  endtask

  // sdram_core stand-in: drives sd_rdy/completions on negedges, checks each accepted command
  initial begin : stub
    logic          st_we;
    logic [AW-1:0] st_a;
    int            st_cdly, st_wait, st_hi;
    bit            st_pend, st_acc;
    iss_t          e;
    st_pend = 0; st_acc = 0; st_wait = -1; st_hi = 0; st_cdly = 0; st_we = 0; st_a = '0;
    sd_rdy = 0; sd_wvalid = 0; sd_rvalid = 0; sd_rdata = '0;
    forever begin
      @(negedge clk);
      sd_wvalid = 0;
      sd_rvalid = 0;
      if (!rst_n) begin
        st_pend = 0; st_acc = 0; st_wait = -1; st_hi = 0; sd_rdy = 0;
      end else begin
        if (st_acc) begin
          chk("strobe_drop", {sd_wr, sd_rd}, 2'b00);
          st_acc = 0;
        end
        if (st_pend) begin
          if (st_cdly == 0) begin
            st_pend = 0;
            if (!never_cmp) begin
              if (st_we) sd_wvalid = 1;
              else begin
                sd_rvalid = 1;
                sd_rdata  = smem.exists(st_a) ? smem[st_a] : '0;
              end
            end
          end else st_cdly--;
        end
        if (spur_now) begin
          sd_wvalid = 1; sd_rvalid = 1; sd_rdata = 32'hBAD0BAD0; spur_now = 0;
        end
        if (sd_wr || sd_rd) begin
          if (st_wait < 0) begin st_wait = rdy_dly; st_hi = 0; end
          st_hi++;
          if (st_wait == 0) begin
            sd_rdy = 1; st_acc = 1; st_wait = -1; issue_cnt++; acc_cyc = cyc + 1;
            chk("strobe_onehot", sd_wr ^ sd_rd, 1);
            chk("strobe_width", st_hi, rdy_dly + 1);
            if (exp_issue_q.size() == 0) fail("issue_extra", "command issued with no request queued");
            else begin
              e = exp_issue_q.pop_front();
              chk("sd_we", sd_wr, e.we);
              chk("sd_addr", sd_addr, e.addr);
              if (e.we) chk("sd_wdata", sd_wdata, e.wdata);
            end
            st_we = sd_wr; st_a = sd_addr;
            if (sd_wr) smem[sd_addr] = sd_wdata;
            st_pend = 1; st_cdly = cmp_dly;
          end else begin
            sd_rdy = 0; st_wait--;
          end
        end else sd_rdy = idle_rdy;
      end
    end
  end

  // Response consumer: handshake completes at the posedge after this negedge
  initial begin : mon
    rsp_t e;
    rsp_ready = 0;
    forever begin
      @(negedge clk);
      rsp_ready = consume_en;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_rsp_q.size() == 0) fail("rsp_extra", "response with nothing expected");
        else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_we", rsp_we, e.we);
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [AW-1:0] ea, input logic [DW-1:0] er);
    int t = 0;
    while (!req_ready && t < 300) begin @(negedge clk); t++; end
    if (!req_ready) begin fail("push_ready", "req_ready never rose"); return; end
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    exp_issue_q.push_back('{we: we, addr: ea, wdata: d});
    exp_rsp_q.push_back('{we: we, rdata: we ? '0 : er});
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic drain(input string n);
    int t = 0;
    while ((exp_rsp_q.size() != 0 || occupancy != 0 || rsp_valid) && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) fail(n, "responses did not drain");
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_ctrl", {req_ready, rsp_valid, rsp_we, sd_wr, sd_rd, err_timeout, occupancy}, '0);
    chk("rst_data", {rsp_rdata, sd_addr}, '0);
    chk("rst_wdata", sd_wdata, '0);
    exp_issue_q.delete();
    exp_rsp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin : main
    vec_t vt[7];
    int   base;
    bit   seen;
    int   t;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rst_n = 1;

    vt[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0000_1004, 32'h0,         0, 2, 1'b1};
    vt[1] = '{1'b0, 32'h0000_1004, 32'h0,         32'h0000_1004, 32'hDEAD_BEEF, 2, 0, 1'b0};
    vt[2] = '{1'b1, 32'h0000_0007, 32'h1234_5678, 32'h0000_0004, 32'h0,         1, 3, 1'b0};
    vt[3] = '{1'b0, 32'h0000_0005, 32'h0,         32'h0000_0004, 32'h1234_5678, 0, 0, 1'b0};
    vt[4] = '{1'b0, 32'h0000_2000, 32'h0,         32'h0000_2000, 32'h0,         3, 1, 1'b1};
    vt[5] = '{1'b1, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hFFFF_FFFC, 32'h0,         0, 5, 1'b0};
    vt[6] = '{1'b0, 32'hFFFF_FFFE, 32'h0,         32'hFFFF_FFFC, 32'hA5A5_A5A5, 1, 1, 1'b1};

    apply_reset();

    for (int i = 0; i < 7; i++) begin
      rdy_dly = vt[i].rdy_dly; cmp_dly = vt[i].cmp_dly; idle_rdy = vt[i].idle_rdy;
      push(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_addr, vt[i].exp_rdata);
      drain("vec_drain");
    end

    // Back-to-back writes then reads, responses in order
    rdy_dly = 0; cmp_dly = 1; idle_rdy = 0;
    for (int i = 0; i < 8; i++) push(1'b1, 32'h100 + 32'(4 * i), 32'(i), 32'h100 + 32'(4 * i), '0);
    for (int i = 0; i < 8; i++) push(1'b0, 32'h100 + 32'(4 * i), '0, 32'h100 + 32'(4 * i), 32'(i));
    drain("b2b_drain");

    // Push into an idle queue, then push while the first is popped
    push(1'b1, 32'h400, 32'h11, 32'h400, '0);
    chk("occ_after_push", occupancy, 1);
    push(1'b1, 32'h404, 32'h22, 32'h404, '0);
    chk("occ_push_pop", occupancy, 1);
    drain("pp_drain");

    // Fill with the consumer stalled
    consume_en = 0;
    base = issue_cnt;
    for (int i = 0; i < 9; i++) push(1'b1, 32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 32'h200 + 32'(4 * i), '0);
    repeat (4) @(negedge clk);
    chk("full_occ", occupancy, DEPTH);
    chk("full_ready", req_ready, 0);
    chk("full_one_issue", issue_cnt - base, 1);
    chk("full_rsp_held", rsp_valid, 1);
    consume_en = 1;
    drain("fill_drain");
    chk("fill_issues", issue_cnt - base, 9);

    // Completion strobes while idle must be ignored
    base = issue_cnt;
    seen = 0;
    spur_now = 1;
    repeat (6) begin @(negedge clk); seen |= rsp_valid; end
    chk("spur_rsp", seen, 0);
    chk("spur_issue", issue_cnt - base, 0);

    // Completion never arrives
    never_cmp = 1; rdy_dly = 1;
    push(1'b1, 32'h300, 32'h77, 32'h300, '0);
    t = 0;
    while (!err_timeout && t < 1500) begin @(negedge clk); t++; end
    if (!err_timeout) fail("tmo_set", "err_timeout never set");
    else begin
      chk("tmo_latency", cyc - acc_cyc, TMO);
      chk("tmo_rsp_valid", rsp_valid, 1);
    end
    drain("tmo_drain");
    never_cmp = 0; rdy_dly = 0;
    push(1'b0, 32'h1004, '0, 32'h1004, 32'hDEAD_BEEF);
    drain("post_tmo_drain");
    chk("tmo_sticky", err_timeout, 1);

    // Reset mid-WAIT with three requests queued
    never_cmp = 1;
    base = issue_cnt;
    for (int i = 0; i < 4; i++) push(1'b0, 32'h100 + 32'(4 * i), '0, 32'h100 + 32'(4 * i), 32'(i));
    repeat (4) @(negedge clk);
    chk("wait_occ", occupancy, 3);
    chk("wait_one_issue", issue_cnt - base, 1);
    apply_reset();
    base = issue_cnt;
    seen = 0;
    repeat (10) begin @(negedge clk); seen |= (sd_wr | sd_rd); end
    chk("post_rst_occ", occupancy, 0);
    chk("post_rst_strobe", seen, 0);
    chk("post_rst_issue", issue_cnt - base, 0);
    chk("post_rst_err", err_timeout, 0);
    never_cmp = 0;
    push(1'b0, 32'h1004, '0, 32'h1004, 32'hDEAD_BEEF);
    drain("post_rst_drain");

    chk("sb_empty", exp_rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
